// File: rtl/zxw_seq_pkg.sv
// Shared types and switch-field positions for the display sequencer.
// The mode encoding matches the two low switch bits directly.
package zxw_seq_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_LFSR   = 2'b10,
        MODE_BOUNCE = 2'b11
    } seq_mode_t;

    localparam int MODE_LO  = 0;
    localparam int MODE_HI  = 1;
    localparam int DIR_BIT  = 2;
    localparam int HOLD_BIT = 3;
    localparam int STEP_LO  = 4;

    localparam logic BDIR_LEFT  = 1'b0;
    localparam logic BDIR_RIGHT = 1'b1;

endpackage

// File: rtl/zxw_prescaler.sv
// Step-rate prescaler: emits one tick every PRESCALE enabled clocks.
// A clear restarts the count and suppresses the tick in that cycle.
module zxw_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    assign tick = en && !clr && (count == LAST);

    // Disabled cycles keep the count, so a released hold resumes mid-interval.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/zxw_seq_display.sv
// Switch-controlled display sequencer: counter, rotate, LFSR and bounce modes
// with a prescaled step rate, hold, and registered step/wrap strobes.
module zxw_seq_display
    import zxw_seq_pkg::*;
#(
    parameter int              DISP_W   = 8,
    parameter int              SW_W     = 5,
    parameter int              PRESCALE = 1,
    parameter logic [DISP_W-1:0] TAPS   = 8'hB8,
    parameter logic [DISP_W-1:0] SEED   = 8'h01
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [SW_W-1:0]   SW_in,
    output logic [DISP_W-1:0] Display_out,
    output logic              Step_out,
    output logic              Wrap_out
);

    localparam int STEP_W = SW_W - STEP_LO;
    localparam int AW     = ((DISP_W > STEP_W) ? DISP_W : STEP_W) + 2;
    localparam logic [DISP_W-1:0] ONE = DISP_W'(1);

    logic [SW_W-1:0]   sw_meta;
    logic [SW_W-1:0]   sw_s;
    seq_mode_t         mode_s;
    seq_mode_t         prev_mode;
    logic              dir_s;
    logic              hold_s;
    logic              mode_change;
    logic              tick;

    logic [DISP_W-1:0] state_q;
    logic [DISP_W-1:0] state_d;
    logic              bdir_q;
    logic              bdir_d;
    logic              step_q;
    logic              step_d;
    logic              wrap_q;
    logic              wrap_d;

    logic [AW-1:0]     step_ext;
    logic [AW-1:0]     state_ext;
    logic [AW-1:0]     sum;
    logic [AW-1:0]     diff;
    logic              carry;
    logic              borrow;

    logic [DISP_W-1:0] rot_left;
    logic [DISP_W-1:0] rot_right;
    logic [DISP_W-1:0] lfsr_next;
    logic [DISP_W-1:0] shl;
    logic [DISP_W-1:0] shr;
    logic              one_hot;

    // Switches are asynchronous; everything downstream sees only sw_s.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            sw_meta <= SW_in;
            sw_s    <= sw_meta;
        end
    end

    assign mode_s      = seq_mode_t'(sw_s[MODE_HI:MODE_LO]);
    assign dir_s       = sw_s[DIR_BIT];
    assign hold_s      = sw_s[HOLD_BIT];
    assign mode_change = (mode_s != prev_mode);

    zxw_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .Clock (Clock),
        .Reset (Reset),
        .en    (!hold_s && !mode_change),
        .clr   (mode_change),
        .tick  (tick)
    );

    // Arithmetic is widened so carry and borrow fall out of the extra bits.
    assign step_ext  = AW'(sw_s[SW_W-1:STEP_LO]) + AW'(1);
    assign state_ext = AW'(state_q);
    assign sum       = state_ext + step_ext;
    assign diff      = state_ext - step_ext;
    assign carry     = |sum[AW-1:DISP_W];
    assign borrow    = (step_ext > state_ext);

    assign rot_left  = {state_q[DISP_W-2:0], state_q[DISP_W-1]};
    assign rot_right = {state_q[0], state_q[DISP_W-1:1]};

    // An all-zero LFSR would lock up, so it is reseeded instead.
    assign lfsr_next = (state_q == '0) ? SEED
                     : ((state_q >> 1) ^ (state_q[0] ? TAPS : '0));

    assign shl     = state_q << 1;
    assign shr     = state_q >> 1;
    assign one_hot = (state_q != '0) && ((state_q & (state_q - ONE)) == '0);

    // A mode change reloads the seed and outranks both tick and hold.
    always_comb begin
        state_d = state_q;
        bdir_d  = bdir_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        if (mode_change) begin
            bdir_d = BDIR_LEFT;
            unique case (mode_s)
                MODE_COUNT:  state_d = '0;
                MODE_ROTATE: state_d = ONE;
                MODE_LFSR:   state_d = SEED;
                MODE_BOUNCE: state_d = ONE;
            endcase
        end else if (tick) begin
            step_d = 1'b1;
            unique case (mode_s)
                MODE_COUNT: begin
                    if (dir_s) begin
                        state_d = diff[DISP_W-1:0];
                        wrap_d  = borrow;
                    end else begin
                        state_d = sum[DISP_W-1:0];
                        wrap_d  = carry;
                    end
                end
                MODE_ROTATE: begin
                    if (dir_s) begin
                        state_d = rot_right;
                        wrap_d  = state_q[0];
                    end else begin
                        state_d = rot_left;
                        wrap_d  = state_q[DISP_W-1];
                    end
                end
                MODE_LFSR: begin
                    state_d = lfsr_next;
                    wrap_d  = (lfsr_next == SEED);
                end
                MODE_BOUNCE: begin
                    if (!one_hot) begin
                        state_d = ONE;
                        bdir_d  = BDIR_LEFT;
                    end else if (bdir_q == BDIR_LEFT) begin
                        state_d = shl;
                        if (shl[DISP_W-1]) begin
                            bdir_d = BDIR_RIGHT;
                            wrap_d = 1'b1;
                        end
                    end else begin
                        state_d = shr;
                        if (shr[0]) begin
                            bdir_d = BDIR_LEFT;
                            wrap_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= '0;
            bdir_q    <= BDIR_LEFT;
            prev_mode <= MODE_COUNT;
            step_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bdir_q    <= bdir_d;
            prev_mode <= mode_s;
            step_q    <= step_d;
            wrap_q    <= wrap_d;
        end
    end

    assign Display_out = state_q;
    assign Step_out    = step_q;
    assign Wrap_out    = wrap_q;

endmodule

// File: tb/tb_zxw_seq_display.sv
// Scoreboard bench for zxw_seq_display: a PRESCALE=1 and a PRESCALE=3 instance
// share clock, reset and switches; expected steps are queued and popped on Step_out.
module tb_zxw_seq_display;

    typedef struct packed {
        logic [7:0] disp;
        logic       wrap;
    } exp_t;

    localparam logic [7:0] BOUNCE_PATH [15] = '{
        8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
        8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02
    };

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] sw_in;
    logic [7:0] disp1, disp3;
    logic       step1, wrap1, step3, wrap3;

    exp_t q1[$];
    exp_t q3[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   wraps1      = 0;

    zxw_seq_display #(
        .DISP_W(8), .SW_W(5), .PRESCALE(1), .TAPS(8'hB8), .SEED(8'h01)
    ) dut1 (
        .Clock(clock), .Reset(reset), .SW_in(sw_in),
        .Display_out(disp1), .Step_out(step1), .Wrap_out(wrap1)
    );

    zxw_seq_display #(
        .DISP_W(8), .SW_W(5), .PRESCALE(3), .TAPS(8'hB8), .SEED(8'h01)
    ) dut3 (
        .Clock(clock), .Reset(reset), .SW_in(sw_in),
        .Display_out(disp3), .Step_out(step3), .Wrap_out(wrap3)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] sw, input int settle);
        sw_in = sw;
        repeat (settle) @(negedge clock);
    endtask

    function automatic logic [7:0] lfsrNext(input logic [7:0] s);
        logic [7:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 8'hB8;
        return t;
    endfunction

    // Pops one expectation per observed step of each instance until both queues drain.
    task automatic drainQueues(input int budget, input bit spacing);
        exp_t e;
        int   n;
        int   last3;
        n     = 0;
        last3 = cyc;
        while ((q1.size() > 0 || q3.size() > 0) && n < budget) begin
            @(negedge clock);
            n++;
            if (step1 && q1.size() > 0) begin
                e = q1.pop_front();
                if (wrap1) wraps1++;
                checkOutput("p1 display", disp1, e.disp);
                checkOutput("p1 wrap", wrap1, e.wrap);
            end
            if (step3 && q3.size() > 0) begin
                e = q3.pop_front();
                checkOutput("p3 display", disp3, e.disp);
                checkOutput("p3 wrap", wrap3, e.wrap);
                if (spacing) checkOutput("p3 step spacing", cyc - last3, 3);
                last3 = cyc;
            end
        end
        if (q1.size() > 0 || q3.size() > 0) begin
            checkOutput("drain timeout pending", q1.size() + q3.size(), 0);
            q1.delete();
            q3.delete();
        end
    endtask

    task automatic waitStep3(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!step3 && n < 12);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] s;
        int         n;
        int         steps;

        reset = 1'b1;
        sw_in = 5'b00000;
        repeat (3) @(negedge clock);
        checkOutput("reset p1 display", disp1, 8'h00);
        checkOutput("reset p1 step", step1, 1'b0);
        checkOutput("reset p1 wrap", wrap1, 1'b0);
        checkOutput("reset p3 display", disp3, 8'h00);
        checkOutput("reset p3 step", step3, 1'b0);
        checkOutput("reset p3 wrap", wrap3, 1'b0);

        // Release: no reload, counting starts on the first edge.
        reset = 1'b0;
        q1.push_back({8'h01, 1'b0});
        q1.push_back({8'h02, 1'b0});
        q1.push_back({8'h03, 1'b0});
        q3.push_back({8'h01, 1'b0});
        drainQueues(12, 1'b1);

        $display("[TB] rotate");
        applyStimulus(5'b00001, 3);
        checkOutput("rotate reload p1", disp1, 8'h01);
        checkOutput("rotate reload p1 step", step1, 1'b0);
        checkOutput("rotate reload p3", disp3, 8'h01);
        checkOutput("rotate reload p3 step", step3, 1'b0);
        s = 8'h01;
        for (int i = 0; i < 6; i++) begin
            s = s << 1;
            q1.push_back({s, 1'b0});
        end
        drainQueues(12, 1'b0);
        applyStimulus(5'b00101, 0);
        q1.push_back({8'h80, 1'b0});
        q1.push_back({8'h01, 1'b1});
        q1.push_back({8'h80, 1'b1});
        q1.push_back({8'h40, 1'b0});
        q1.push_back({8'h20, 1'b0});
        drainQueues(12, 1'b0);

        $display("[TB] lfsr");
        applyStimulus(5'b00010, 3);
        checkOutput("lfsr reload p1", disp1, 8'h01);
        s = 8'h01;
        for (int i = 0; i < 255; i++) begin
            s = lfsrNext(s);
            q1.push_back({s, (s == 8'h01)});
        end
        wraps1 = 0;
        drainQueues(300, 1'b0);
        checkOutput("lfsr wraps per period", wraps1, 1);

        $display("[TB] count");
        applyStimulus(5'b10100, 3);
        checkOutput("count reload p1", disp1, 8'h00);
        q1.push_back({8'hFE, 1'b1});
        q1.push_back({8'hFC, 1'b0});
        drainQueues(8, 1'b0);
        applyStimulus(5'b00100, 0);
        q1.push_back({8'hFA, 1'b0});
        q1.push_back({8'hF8, 1'b0});
        q1.push_back({8'hF7, 1'b0});
        q1.push_back({8'hF6, 1'b0});
        q1.push_back({8'hF5, 1'b0});
        drainQueues(10, 1'b0);
        applyStimulus(5'b10000, 0);
        q1.push_back({8'hF4, 1'b0});
        q1.push_back({8'hF3, 1'b0});
        q1.push_back({8'hF5, 1'b0});
        q1.push_back({8'hF7, 1'b0});
        q1.push_back({8'hF9, 1'b0});
        q1.push_back({8'hFB, 1'b0});
        q1.push_back({8'hFD, 1'b0});
        q1.push_back({8'hFF, 1'b0});
        q1.push_back({8'h01, 1'b1});
        q1.push_back({8'h03, 1'b0});
        drainQueues(16, 1'b0);

        $display("[TB] bounce");
        applyStimulus(5'b00011, 3);
        checkOutput("bounce reload p1", disp1, 8'h01);
        checkOutput("bounce reload p3", disp3, 8'h01);
        for (int i = 0; i < 15; i++) begin
            q1.push_back({BOUNCE_PATH[i], (i == 6 || i == 13)});
            q3.push_back({BOUNCE_PATH[i], (i == 6 || i == 13)});
        end
        drainQueues(60, 1'b1);

        // Hold lands with the P=3 prescaler at its last count.
        $display("[TB] hold");
        applyStimulus(5'b01011, 3);
        checkOutput("hold p1 frozen value", disp1, 8'h20);
        checkOutput("hold p3 frozen value", disp3, 8'h02);
        steps = 0;
        repeat (8) begin
            @(negedge clock);
            if (step1 || wrap1 || step3 || wrap3) steps++;
        end
        checkOutput("hold strobes", steps, 0);
        checkOutput("hold p1 still", disp1, 8'h20);
        checkOutput("hold p3 still", disp3, 8'h02);

        applyStimulus(5'b00011, 0);
        waitStep3(n);
        checkOutput("resume latency p3", n, 3);
        checkOutput("resume p3 display", disp3, 8'h04);
        checkOutput("resume p3 wrap", wrap3, 1'b0);

        applyStimulus(5'b01001, 3);
        checkOutput("held reload p1", disp1, 8'h01);
        checkOutput("held reload p1 step", step1, 1'b0);
        checkOutput("held reload p3", disp3, 8'h01);
        checkOutput("held reload p3 step", step3, 1'b0);
        steps = 0;
        repeat (6) begin
            @(negedge clock);
            if (step1 || step3) steps++;
        end
        checkOutput("held after reload strobes", steps, 0);
        checkOutput("held after reload p3", disp3, 8'h01);

        applyStimulus(5'b00001, 0);
        waitStep3(n);
        checkOutput("release latency p3", n, 5);
        checkOutput("release p3 display", disp3, 8'h02);
        checkOutput("release p3 wrap", wrap3, 1'b0);
        checkOutput("release p1 display", disp1, 8'h08);

        // Asynchronous reset between edges while p1 is stepping every cycle.
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset p1 display", disp1, 8'h00);
        checkOutput("async reset p1 step", step1, 1'b0);
        checkOutput("async reset p1 wrap", wrap1, 1'b0);
        checkOutput("async reset p3 display", disp3, 8'h00);
        checkOutput("async reset p3 step", step3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
